// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed serial transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_e;

  localparam logic        LINE_IDLE   = 1'b1;
  localparam int unsigned FRAME_CNT_W = 16;

  // Counter width helper that never returns zero for tiny ranges.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer: one-cycle tick on the last clk of every CLKS_PER_BIT period.
module fifo_uart_tx_baud_tick_gen
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned     CNT_W = clog2_min1(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered from the next count, so it lines up with cnt_q == LAST.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the sync FIFO one byte at a time and sends each as a start/data/stop
// serial frame, LSB first, with a running count of completed frames.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_en,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_rd_en,
  output logic                   tx,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned      IDX_W    = clog2_min1(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   tx_q, tx_d;
  logic                   rd_en_q, rd_en_d;
  logic                   busy_q, busy_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   baud_clr_c;
  logic                   tick;

  // Bit timing restarts in LOAD so the start bit gets a full period.
  assign baud_clr_c = (state_q == ST_LOAD);

  fifo_uart_tx_baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clr_i (baud_clr_c),
    .tick_o(tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    tx_d        = tx_q;
    frame_cnt_d = frame_cnt_q;
    rd_en_d     = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = LINE_IDLE;
        if (tx_en && !fifo_empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d = fifo_data;
        tx_d    = ~LINE_IDLE;
        state_d = ST_START;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_STOP;
            tx_d    = LINE_IDLE;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_d[0];
          end
        end
      end
      ST_STOP: begin
        tx_d = LINE_IDLE;
        if (tick) begin
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          state_d     = (tx_en && !fifo_empty) ? ST_FETCH : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase

    // Registered from the next state so the read strobe is exactly the FETCH cycle.
    rd_en_d = (state_d == ST_FETCH);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      tx_q        <= LINE_IDLE;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural sync FIFO and a byte scoreboard.
module tb_fifo_uart_tx;

  localparam int unsigned W         = 8;
  localparam int unsigned CPB       = 4;
  localparam int unsigned FRAME_LEN = (W + 2) * CPB;

  logic         clk;
  logic         rst;
  logic         tx_en;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_rd_en;
  logic         tx;
  logic         busy;
  logic [15:0]  frame_cnt;

  fifo_uart_tx #(
    .WIDTH       (W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sync FIFO: registered read data one cycle after the strobe.
  logic [W-1:0] mem [0:63];
  int           wr_ptr      = 0;
  int           rd_ptr      = 0;
  int           rd_cnt      = 0;
  int           rd_on_empty = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (wr_ptr == rd_ptr) begin
        rd_on_empty <= rd_on_empty + 1;
      end else begin
        fifo_data <= mem[rd_ptr % 64];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  logic [W-1:0] sb [$];
  int           vectors    = 0;
  int           miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [W-1:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
    sb.push_back(b);
  endtask

  // Wait for a start bit, sample every cycle of the frame and score it.
  // drop_at/rst_at are sample indices at which tx_en drops or reset hits (-1 = never).
  task automatic recv_frame(input int drop_at, input int rst_at, output int gap);
    logic [FRAME_LEN-1:0] obs;
    logic [FRAME_LEN-1:0] exp;
    logic [W-1:0]         b;
    logic                 started;
    int                   pos;
    gap     = 0;
    started = 1'b0;
    obs     = '0;
    for (int k = 0; k < 200 && !started; k++) begin
      @(negedge clk);
      if (tx === 1'b0) started = 1'b1;
      else gap++;
    end
    check("start_seen", 64'(started), 64'd1);
    if (!started) return;
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      if (i > 0) @(negedge clk);
      if (i == drop_at) tx_en = 1'b0;
      if (i == rst_at) begin
        rst = 1'b0;
        #1;
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        if (sb.size() > 0) void'(sb.pop_front());
        return;
      end
      obs[i] = tx;
    end
    check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    b = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      pos = i / int'(CPB);
      if (pos == 0) exp[i] = 1'b0;
      else if (pos == int'(W) + 1) exp[i] = 1'b1;
      else exp[i] = b[pos-1];
    end
    check("frame", 64'(obs), 64'(exp));
  endtask

  initial begin
    int          gap;
    int          rd_before;
    logic [15:0] exp_cnt;
    logic        bad_tx, bad_rd, bad_busy;

    rst       = 1'b1;
    tx_en     = 1'b0;
    fifo_data = '0;
    exp_cnt   = 16'd0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_tx", 64'(tx), 64'd1);
    check("reset_rd_en", 64'(fifo_rd_en), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    rst = 1'b1;

    // Single 0xA5 frame with latency checks.
    tx_en     = 1'b1;
    rd_before = rd_cnt;
    push_byte(8'hA5);
    @(negedge clk);
    check("t1_rd_en_hi", 64'(fifo_rd_en), 64'd1);
    check("t1_busy_hi", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_rd_en_lo", 64'(fifo_rd_en), 64'd0);
    check("t1_tx_before_start", 64'(tx), 64'd1);
    recv_frame(-1, -1, gap);
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    check("t1_frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    check("t1_busy_lo", 64'(busy), 64'd0);
    check("t1_rd_pulses", 64'(rd_cnt - rd_before), 64'd1);

    // Back-to-back 0x00 then 0xFF.
    rd_before = rd_cnt;
    push_byte(8'h00);
    push_byte(8'hFF);
    recv_frame(-1, -1, gap);
    check("t2_start_latency", 64'(gap), 64'd2);
    recv_frame(-1, -1, gap);
    check("t2_gap", 64'(gap), 64'd2);
    exp_cnt = exp_cnt + 16'd2;
    @(negedge clk);
    check("t2_frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    check("t2_rd_pulses", 64'(rd_cnt - rd_before), 64'd2);

    // Empty FIFO: nothing happens.
    bad_tx = 1'b0; bad_rd = 1'b0; bad_busy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx = 1'b1;
      if (fifo_rd_en !== 1'b0) bad_rd = 1'b1;
      if (busy !== 1'b0) bad_busy = 1'b1;
    end
    check("t3_tx_idle", 64'(bad_tx), 64'd0);
    check("t3_no_rd", 64'(bad_rd), 64'd0);
    check("t3_not_busy", 64'(bad_busy), 64'd0);

    // tx_en dropped during data bit 3 with three words queued.
    rd_before = rd_cnt;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    recv_frame(4 * int'(CPB) + 1, -1, gap);
    exp_cnt = exp_cnt + 16'd1;
    bad_tx = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx = 1'b1;
    end
    check("t4_line_idle", 64'(bad_tx), 64'd0);
    check("t4_rd_pulses", 64'(rd_cnt - rd_before), 64'd1);
    check("t4_frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    check("t4_remaining", 64'(wr_ptr - rd_ptr), 64'd2);

    // Reset during data bit 5; the following byte must still go out intact.
    tx_en = 1'b1;
    recv_frame(-1, 6 * int'(CPB) + 1, gap);
    exp_cnt = 16'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    recv_frame(-1, -1, gap);
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    check("t5_frame_cnt", 64'(frame_cnt), 64'(exp_cnt));

    // frame_cnt wrap from 0xFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check("t6_preload", 64'(frame_cnt), 64'hFFFF);
    push_byte(8'h5A);
    recv_frame(-1, -1, gap);
    @(negedge clk);
    check("t6_wrap", 64'(frame_cnt), 64'h0);

    check("no_read_on_empty", 64'(rd_on_empty), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
